// File: rtl/spi_cfg_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : spi_cfg_sequencer
//  Brief    : Walks a word table and issues each word as one 24-bit SPI
//             transaction through spi_module. It captures the return word of
//             read-flagged entries and inserts an idle gap between words.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_cfg_sequencer #(
   parameter int DATA_WIDTH     = 24,
   parameter int ADDR_W         = 6,
   parameter int GAP_CYCLES     = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start_i,
   input  logic                  abort_i,
   input  logic [ADDR_W:0]       num_words_i,
   output logic [ADDR_W-1:0]     tbl_addr_o,
   output logic                  tbl_rd_o,
   input  logic [DATA_WIDTH-1:0] tbl_data_i,
   output logic                  sdo_valid_o,
   output logic [DATA_WIDTH-1:0] sdo_data_o,
   input  logic                  sdo_ready_i,
   output logic                  sdi_ready_o,
   input  logic [DATA_WIDTH-1:0] sdi_data_i,
   input  logic                  sdi_valid_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  err_o,
   output logic [DATA_WIDTH-1:0] rd_data_o,
   output logic                  rd_valid_o,
   output logic [ADDR_W:0]       word_idx_o
);

   // The counter widths are chosen so that a value of 1 for either parameter
   // still gives a counter at least one bit wide.
   localparam int                 c_to_w      = $clog2(TIMEOUT_CYCLES + 1);
   localparam int                 c_gap_w     = $clog2(GAP_CYCLES + 1);
   localparam logic [c_to_w-1:0]  c_to_last   = c_to_w'(TIMEOUT_CYCLES - 1);
   localparam logic [c_gap_w-1:0] c_gap_last  = c_gap_w'(GAP_CYCLES - 1);
   // The largest legal word count is 2^ADDR_W. Larger requests are clamped to it.
   localparam logic [ADDR_W:0]    c_max_words = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0]    c_idx_one   = (ADDR_W + 1)'(1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_LOAD   = 3'd2,
      S_SEND   = 3'd3,
      S_RECV   = 3'd4,
      S_GAP    = 3'd5,
      S_FINISH = 3'd6
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic                  w_accept;
   logic                  w_sdi_hs;
   logic                  w_timeout;
   logic [ADDR_W:0]       r_count;
   logic [ADDR_W:0]       r_word_idx;
   logic [DATA_WIDTH-1:0] r_sdo_data;
   logic [DATA_WIDTH-1:0] r_rd_data;
   logic                  r_rd_valid;
   logic                  r_err;
   logic [c_to_w-1:0]     r_to_cnt;
   logic [c_gap_w-1:0]    r_gap_cnt;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state decode and per-cycle event strobes
   always_comb begin
      w_next    = r_state;
      w_accept  = 1'b0;
      w_sdi_hs  = 1'b0;
      w_timeout = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start_i) begin
               w_accept = 1'b1;
               w_next   = (num_words_i == '0) ? S_FINISH : S_FETCH;
            end
         end
         S_FETCH: w_next = S_LOAD;
         S_LOAD:  w_next = S_SEND;
         S_SEND: begin
            if (sdo_ready_i) begin
               w_next = S_RECV;
            end
         end
         S_RECV: begin
            // A return word on the last allowed cycle still counts as success.
            if (sdi_valid_i) begin
               w_sdi_hs = 1'b1;
               w_next   = S_GAP;
            end else if (r_to_cnt == c_to_last) begin
               w_timeout = 1'b1;
               w_next    = S_FINISH;
            end
         end
         S_GAP: begin
            if (r_gap_cnt == c_gap_last) begin
               w_next = ((r_word_idx == r_count) || abort_i) ? S_FINISH : S_FETCH;
            end
         end
         S_FINISH: w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   // Sequence bookkeeping: word count, index, outgoing word, read capture, error
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count    <= '0;
         r_word_idx <= '0;
         r_sdo_data <= '0;
         r_rd_data  <= '0;
         r_rd_valid <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_rd_valid <= 1'b0;
         if (w_accept) begin
            r_word_idx <= '0;
            r_err      <= 1'b0;
            r_count    <= (num_words_i > c_max_words) ? c_max_words : num_words_i;
         end
         if (r_state == S_LOAD) begin
            r_sdo_data <= tbl_data_i;
         end
         if (w_sdi_hs) begin
            r_word_idx <= r_word_idx + c_idx_one;
            if (r_sdo_data[DATA_WIDTH-1]) begin
               r_rd_data  <= sdi_data_i;
               r_rd_valid <= 1'b1;
            end
         end
         if (w_timeout) begin
            r_err <= 1'b1;
         end
      end
   end

   // Receive-timeout and inter-word gap counters, both restarting at state entry
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_to_cnt  <= '0;
         r_gap_cnt <= '0;
      end else begin
         r_to_cnt  <= (r_state == S_RECV) ? r_to_cnt + 1'b1 : '0;
         r_gap_cnt <= (r_state == S_GAP) ? r_gap_cnt + 1'b1 : '0;
      end
   end

   assign tbl_addr_o  = r_word_idx[ADDR_W-1:0];
   assign tbl_rd_o    = (r_state == S_FETCH);
   assign sdo_valid_o = (r_state == S_SEND);
   assign sdo_data_o  = r_sdo_data;
   assign sdi_ready_o = (r_state == S_RECV);
   assign busy_o      = (r_state != S_IDLE);
   assign done_o      = (r_state == S_FINISH);
   assign err_o       = r_err;
   assign rd_data_o   = r_rd_data;
   assign rd_valid_o  = r_rd_valid;
   assign word_idx_o  = r_word_idx;

endmodule
`default_nettype wire

// File: doc/spi_cfg_sequencer.md
Name: spi_cfg_sequencer

Overview:
- Sequencer that drives the 24-bit spi_module master and programs the image-sensor register map from a word table.
- On start, fetches N words from a synchronous table RAM/ROM and issues each word as one SPI transaction.
- Waits for the full-duplex return word, captures it when the word is a read, then enforces an inter-word gap.
- Sits between the top-level configuration FSM / host register block and spi_module; it is the only requester of spi_module.

Parameters:
- DATA_WIDTH, 24, SPI word width; matches spi_module.
- ADDR_W, 6, table address width; up to 64 words.
- GAP_CYCLES, 4, idle clk cycles between transactions (CS high time margin); minimum 1.
- TIMEOUT_CYCLES, 1024, maximum clk cycles waiting for sdi_valid_i per word.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start_i  in  1  single-cycle pulse; begin sequence; ignored while busy_o=1
- abort_i  in  1  level; stop at next word boundary
- num_words_i  in  ADDR_W+1  word count, sampled on start; 0 is legal
- tbl_addr_o  out  ADDR_W  table read address
- tbl_rd_o  out  1  table read strobe
- tbl_data_i  in  DATA_WIDTH  table data, valid 1 cycle after tbl_rd_o
- sdo_valid_o  out  1  to spi_module sdo_valid_i
- sdo_data_o  out  DATA_WIDTH  to spi_module sdo_data_i
- sdo_ready_i  in  1  from spi_module sdo_ready_o
- sdi_ready_o  out  1  to spi_module sdi_ready_i
- sdi_data_i  in  DATA_WIDTH  from spi_module sdi_data_o
- sdi_valid_i  in  1  from spi_module sdi_valid_o
- busy_o  out  1  sequence in progress
- done_o  out  1  single-cycle pulse at sequence end, including abort and error
- err_o  out  1  sticky timeout flag; cleared on the next accepted start
- rd_data_o  out  DATA_WIDTH  return word of the last read-flagged transaction
- rd_valid_o  out  1  single-cycle pulse when rd_data_o updates
- word_idx_o  out  ADDR_W+1  number of words completed in the current or last sequence

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; all counters 0.
- Word format: bit DATA_WIDTH-1 = read flag (1 = read). The whole word is sent unmodified.
- FSM states: IDLE, FETCH, LOAD, SEND, RECV, GAP, FINISH.
- IDLE:
  - On start_i with num_words_i=0: go to FINISH.
  - On start_i with num_words_i>0: latch the count, clear word_idx_o, clear err_o, go to FETCH.
- FETCH: assert tbl_rd_o for 1 cycle with tbl_addr_o = word_idx_o[ADDR_W-1:0]; go to LOAD.
- LOAD: register tbl_data_i into sdo_data_o; go to SEND.
- SEND:
  - sdo_valid_o=1; sdo_data_o held stable.
  - Transfer occurs on the first clk edge with sdo_valid_o & sdo_ready_i. sdo_valid_o drops the following cycle; go to RECV.
  - No timeout applies in SEND.
- RECV:
  - sdi_ready_o=1; the timeout counter runs from 0.
  - On sdi_valid_i & sdi_ready_o:
    - If the sent word's read flag is set: rd_data_o <= sdi_data_i, pulse rd_valid_o.
    - Increment word_idx_o; go to GAP.
  - If the counter reaches TIMEOUT_CYCLES-1 without sdi_valid_i: set err_o, drop sdi_ready_o, go to FINISH.
- GAP:
  - Count GAP_CYCLES cycles.
  - Then: if word_idx_o == latched count or abort_i=1, go to FINISH; else go to FETCH.
- FINISH: pulse done_o for 1 cycle; go to IDLE.
- busy_o = 1 in every state except IDLE.
- Per-word latency with ideal spi_module, from the FETCH cycle to the GAP entry: 3 cycles + SPI handshake wait + SPI shift time.
- Abort:
  - Sampled only in GAP, so an in-flight SPI transaction always completes.
  - abort_i high at start is still accepted: the first word is sent, then the sequence ends.
- start_i while busy_o=1 is ignored, with no queuing.
- A simultaneous start_i and done_o cycle (in FINISH) is ignored.
- Index wrap: the table address uses the low ADDR_W bits. num_words_i = 2^ADDR_W is legal; larger values are clamped to 2^ADDR_W.
- Reset mid-operation: all outputs return to 0 immediately (async). This may truncate a spi_module transaction, which is reset by the same rst_n.

Test Plan:
- Reset with rst_n=0 mid-SEND -> all outputs 0 asynchronously; after release, FSM in IDLE and busy_o=0.
- Table {0x0A1234, 0x0B5678, 0x0C9ABC}, num_words_i=3, model spi returns 0x000000 -> exactly three sdo_valid_o handshakes with those data in order; ≥4 idle cycles between them; word_idx_o=3; one done_o pulse; rd_valid_o never asserted.
- Table {0x812300}, num_words_i=1, model returns 0x0000C5 -> rd_data_o=0x0000C5; one rd_valid_o pulse, in the cycle after sdi handshake; done_o follows.
- num_words_i=0 start -> busy_o high 1 cycle, done_o pulse, no tbl_rd_o and no sdo_valid_o.
- Model never asserts sdi_valid_i -> err_o=1 exactly 1024 cycles after RECV entry; done_o pulse; word_idx_o=0; next start clears err_o.
- num_words_i=5 with abort_i asserted during word 2 shift -> word 2 completes; no third tbl_rd_o; word_idx_o=2; done_o pulse.
